mem_stage: RTL

Memory-access stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register, and performs the loads and stores for the current instruction. Accesses go either to data memory, through a req/ack handshake with a watchdog, or to the single-cycle MMIO region. It stalls upstream stages while a data-memory access is outstanding, and presents aligned, sign-extended load data plus the forwarded control fields to MEM/WB.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage_lsu_align.sv | 48 ++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared load/store encodings, MEM-stage FSM states and address map
// defaults for the 5-stage RISC-V pipeline.
package riscv_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Undefined encodings are word accesses, so they need word alignment.
    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        if (is_byte(f3)) return 1'b0;
        if (is_half(f3)) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus and single-cycle MMIO bus seen by the
// MEM stage (master) and the memory system (slave).
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        io_re;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr,
        output dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata,
        output io_re, io_we, io_addr, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr,
        input  dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata,
        input  io_re, io_we, io_addr, io_wdata,
        output io_rdata
    );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store byte enables / replicated data and
// load lane extraction with sign or zero extension.
module lsu_align
    import riscv_defs::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic        sx;

    assign byte_sh = rdata_i >> {off_i, 3'b000};
    assign half_sh = rdata_i >> {off_i[1], 4'b0000};
    assign sx      = ~funct3_i[2];

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        unique case (1'b1)
            is_byte(funct3_i): begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sx & byte_sh[7]}},
                           byte_sh[7:0]};
            end
            is_half(funct3_i): begin
                be_o    = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sx & half_sh[15]}},
                           half_sh[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: dmem req/ack with watchdog, single-cycle MMIO, stall.
// Optional misaligned-access trap: MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
    import riscv_defs::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_write,
    input  logic        ex_memtoreg,
    output logic        stall,
    mem_stage_if.master bus,
    output logic        mem_valid,
    output logic        mem_reg_write,
    output logic        mem_memtoreg,
    output logic        mem_io_write,
    output logic [4:0]  mem_rd_addr,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_mem_data,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        live, is_mem, is_io, mis;
    logic        io_acc, dm_acc, abort, ack, stall_w;
    logic [3:0]  be;
    logic [31:0] wdata_sh, rdata_ext, rdata_src;

    assign live   = rstn & ex_valid;
    assign is_mem = live & (ex_mem_read | ex_mem_write);
    assign is_io  = ex_addr >= IO_BASE;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign mis = is_mem & misaligned(ex_funct3, ex_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign io_acc = is_mem & is_io & ~mis;
    assign dm_acc = is_mem & ~is_io & ~mis;

    // Last watchdog cycle: request is withdrawn, a late ack is ignored.
    assign abort   = dm_acc & (state_q == MEM_WAIT) & (cnt_q >= TO);
    assign ack     = dm_acc & ~abort & bus.dmem_ack;
    assign stall_w = dm_acc & ~abort & ~bus.dmem_ack;

    assign rdata_src = io_acc ? bus.io_rdata : bus.dmem_rdata;

    lsu_align u_align (
        .funct3_i (ex_funct3),
        .off_i    (ex_addr[1:0]),
        .wdata_i  (ex_wdata),
        .rdata_i  (rdata_src),
        .be_o     (be),
        .wdata_o  (wdata_sh),
        .rdata_o  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall          = stall_w;
        bus.dmem_req   = dm_acc & ~abort;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_be    = '0;
        bus.io_re      = io_acc & ex_mem_read;
        bus.io_we      = io_acc & ex_mem_write;
        bus.io_addr    = '0;
        bus.io_wdata   = '0;
        mem_valid      = live & ~stall_w;
        mem_reg_write  = 1'b0;
        mem_memtoreg   = 1'b0;
        mem_io_write   = io_acc & ex_mem_write;
        mem_rd_addr    = ex_rd_addr;
        mem_alu_result = ex_addr;
        mem_mem_data   = '0;
        bus_err        = abort;
        misalign       = mis;

        unique case (state_q)
            MEM_IDLE: begin
                if (stall_w) begin
                    state_d = MEM_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (stall_w) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (dm_acc & ~abort) begin
            bus.dmem_we   = ex_mem_write;
            bus.dmem_addr = {ex_addr[31:2], 2'b00};
            bus.dmem_be   = be;
            if (ex_mem_write) bus.dmem_wdata = wdata_sh;
        end
        if (io_acc) begin
            bus.io_addr = ex_addr;
            if (ex_mem_write) bus.io_wdata = wdata_sh;
        end
        if (mem_valid) begin
            mem_reg_write = ex_reg_write & ~abort & ~mis;
            mem_memtoreg  = ex_memtoreg;
        end
        if (ex_mem_read & (io_acc | ack)) begin
            mem_mem_data = rdata_ext;
        end
    end

endmodule
